// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared encodings and helpers for the load/store unit: access
//            size codes, FSM state codes, the byte-select mask generator and
//            the alignment legality check.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings as presented by the memory stage
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // FSM state encodings
    localparam int         STATE_W = 2;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Little-endian byte-lane select for an access of the given size at
    // the given byte offset within the word. Illegal sizes select nothing.
    function automatic logic [3:0] sel_mask(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << offset;
            SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // An access is legal when its size is defined and it is naturally
    // aligned: halfwords on even addresses, words on multiples of four.
    function automatic logic is_legal(input logic [1:0] size,
                                      input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            SZ_WORD: ok = (offset == 2'b00);
            SZ_ILL:  ok = 1'b0;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Purely combinational data alignment for the load/store unit.
//            Store side: replicate right-justified store data across all
//            byte lanes and generate the matching select mask.
//            Load side: shift the addressed lane down to bit 0, truncate to
//            the access size and sign- or zero-extend to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    // store steering, driven from the live request
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_offset,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_sel,
    output logic [31:0] o_st_data,

    // load extraction, driven from the attributes latched at acceptance
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_offset,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;
    logic        w_sign;

    // Store lane steering: replicating the data lets the select mask alone
    // pick the lanes, so no per-offset data mux is needed.
    always_comb begin
        o_st_sel = sel_mask(i_st_size, i_st_offset);
        case (i_st_size)
            SZ_BYTE: o_st_data = {4{i_st_wdata[7:0]}};
            SZ_HALF: o_st_data = {2{i_st_wdata[15:0]}};
            default: o_st_data = i_st_wdata;
        endcase
    end

    // Bring the addressed byte lane down to bit 0.
    assign w_shifted = i_ld_raw >> {i_ld_offset, 3'b000};

    // Truncate to the access size and extend to the full word.
    always_comb begin
        w_sign    = 1'b0;
        o_ld_data = w_shifted;
        case (i_ld_size)
            SZ_BYTE: begin
                w_sign    = ~i_ld_unsigned & w_shifted[7];
                o_ld_data = {{24{w_sign}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                w_sign    = ~i_ld_unsigned & w_shifted[15];
                o_ld_data = {{16{w_sign}}, w_shifted[15:0]};
            end
            default: begin
                w_sign    = 1'b0;
                o_ld_data = w_shifted;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit between the memory stage and the Wishbone unit.
//            Accepts one byte/half/word access at a time, checks alignment,
//            steers store data onto byte lanes, raises the Wishbone unit's
//            read/write request lines, extends returned load data and stalls
//            the pipeline for the whole transfer.
// Revision : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk_i,
    input  logic            rst_i,

    // memory-stage request
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            kill_i,

    // memory-stage response
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            bus_err_o,

    // Wishbone unit control
    output logic            wbm_we_o,
    output logic            wbm_re_o,
    output logic            wbm_kill_o,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,

    // Wishbone unit data path
    output logic [XLEN-1:0] wbs_adr_o,
    output logic [XLEN-1:0] wbs_dat_o,
    output logic [3:0]      wbs_sel_o,
    input  logic [XLEN-1:0] wbs_dat_i
);

    logic [STATE_W-1:0] r_state;

    // attributes of the accepted access, needed when the data returns
    logic [1:0]         r_size;
    logic [1:0]         r_offset;
    logic               r_unsigned;
    logic               r_is_store;

    // registered outputs
    logic               r_we;
    logic               r_re;
    logic               r_done;
    logic               r_misaligned;
    logic               r_bus_err;
    logic [XLEN-1:0]    r_rdata;
    logic [XLEN-1:0]    r_adr;
    logic [XLEN-1:0]    r_dat;
    logic [3:0]         r_sel;

    logic               w_legal;
    logic               w_req;
    logic               w_idle;
    logic               w_busy;
    logic [3:0]         w_st_sel;
    logic [XLEN-1:0]    w_st_data;
    logic [XLEN-1:0]    w_ld_data;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_busy  = (r_state == ST_BUSY);
    assign w_legal = is_legal(req_size_i, req_addr_i[1:0]);
    assign w_req   = req_valid_i & ~kill_i;

    lsu_align u_align (
        .i_st_size     (req_size_i),
        .i_st_offset   (req_addr_i[1:0]),
        .i_st_wdata    (req_wdata_i),
        .o_st_sel      (w_st_sel),
        .o_st_data     (w_st_data),
        .i_ld_size     (r_size),
        .i_ld_offset   (r_offset),
        .i_ld_unsigned (r_unsigned),
        .i_ld_raw      (wbs_dat_i),
        .o_ld_data     (w_ld_data)
    );

    // Stall covers the acceptance cycle and the whole bus transfer; the
    // DONE cycle releases the pipeline so the result can be consumed.
    assign stall_o    = w_busy | (w_idle & w_req & w_legal);

    // Abort is only meaningful while a transfer is outstanding, and a
    // simultaneous ack or error wins over the flush.
    assign wbm_kill_o = w_busy & kill_i & ~wbm_ack_i & ~wbm_err_i;

    assign done_o       = r_done;
    assign rdata_o      = r_rdata;
    assign misaligned_o = r_misaligned;
    assign bus_err_o    = r_bus_err;
    assign wbm_we_o     = r_we;
    assign wbm_re_o     = r_re;
    assign wbs_adr_o    = r_adr;
    assign wbs_dat_o    = r_dat;
    assign wbs_sel_o    = r_sel;

    // Access sequencing: accept, wait for ack/err/kill, signal completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_size       <= SZ_BYTE;
            r_offset     <= 2'b00;
            r_unsigned   <= 1'b0;
            r_is_store   <= 1'b0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            r_rdata      <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= 4'b0000;
        end else begin
            // status outputs are single-cycle pulses
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_legal) begin
                            r_adr      <= {req_addr_i[XLEN-1:2], 2'b00};
                            r_sel      <= w_st_sel;
                            r_dat      <= w_st_data;
                            r_size     <= req_size_i;
                            r_offset   <= req_addr_i[1:0];
                            r_unsigned <= req_unsigned_i;
                            r_is_store <= req_we_i;
                            r_we       <= req_we_i;
                            r_re       <= ~req_we_i;
                            r_state    <= ST_BUSY;
                        end else begin
                            // fault reported, no bus activity started
                            r_misaligned <= 1'b1;
                        end
                    end
                end

                ST_BUSY: begin
                    // Requests drop on the same edge that samples ack/err so
                    // the Wishbone unit never sees a stale request on return
                    // to its idle state.
                    if (wbm_err_i) begin
                        r_we      <= 1'b0;
                        r_re      <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (wbm_ack_i) begin
                        r_we    <= 1'b0;
                        r_re    <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_is_store) begin
                            r_rdata <= w_ld_data;
                        end
                        r_state <= ST_DONE;
                    end else if (kill_i) begin
                        r_we    <= 1'b0;
                        r_re    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_DONE: begin
                    // completion cycle; any request here is ignored
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_we    <= 1'b0;
                    r_re    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
